divisor_sequencial_4bits: RTL
=============================

DIVISOR_SEQUENCIAL_4BITS -- requirements
Module: divisor_sequencial_4bits

Interface
REQ-001 Parameters SHALL be none; all widths are fixed (4-bit operands, 5-bit partial remainder).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 iniciar  input  1  start request; sampled only in state OCIOSO.
REQ-005 dividendo  input  4  unsigned dividend; sampled with iniciar.
REQ-006 divisor  input  4  unsigned divisor; sampled with iniciar.
REQ-007 quociente  output  4  registered unsigned quotient of the last completed operation.
REQ-008 resto  output  4  registered unsigned remainder of the last completed operation.
REQ-009 pronto  output  1  one-cycle completion pulse, registered.
REQ-010 ocupado  output  1  high while in CALC or FIM, registered.
REQ-011 erro_div0  output  1  registered; set with pronto when the sampled divisor was 0.

Function
REQ-012 The block SHALL be a restoring divider with states OCIOSO, CALC, FIM.
REQ-013 In OCIOSO with iniciar=1 at an edge, the block SHALL latch dividendo and divisor, clear the 5-bit partial remainder R, load a 2-bit iteration counter with 3, and go to CALC; if the latched divisor is 0 it SHALL go to FIM instead.
REQ-014 In OCIOSO with iniciar=0, all state SHALL hold.
REQ-015 Each CALC edge SHALL shift {R, Q} left by one (Q MSB into R LSB), form the 6-bit trial difference R_shifted - {0,D}, and if non-negative store it into R and set Q LSB to 1, otherwise keep R_shifted and set Q LSB to 0.
REQ-016 CALC SHALL last exactly 4 edges; on the edge where the counter equals 0 the block SHALL go to FIM, load quociente/resto from the final Q/R[3:0], and set pronto=1.
REQ-017 Latency SHALL be 4 cycles: pronto is high in the cycle following the 4th edge after the edge that sampled iniciar.
REQ-018 Divide-by-zero SHALL give erro_div0=1, quociente=4'hF, resto=dividendo, and pronto=1 in the cycle following the sampling edge (latency 1).
REQ-019 FIM SHALL last exactly one cycle, then return to OCIOSO, clearing pronto; erro_div0 SHALL clear at the next accepted iniciar.
REQ-020 iniciar while in CALC or FIM SHALL be ignored, with no queuing.
REQ-021 iniciar held high continuously SHALL start a new operation on each return to OCIOSO, using the operand values present at that edge.
REQ-022 quociente and resto SHALL change only on entry to FIM and hold until the next completion.
REQ-023 Operand inputs changing during CALC SHALL not affect the result.
REQ-024 The R field SHALL never exceed 5 bits; the final remainder is always less than the divisor, so resto = R[3:0] with R[4]=0.
REQ-025 ocupado SHALL be 1 from the edge after acceptance through the FIM cycle inclusive, and 0 otherwise.

Reset
REQ-026 rst=1 SHALL immediately force OCIOSO, with quociente=0, resto=0, pronto=0, ocupado=0, erro_div0=0, and the counter, R, Q and the latched divisor cleared.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no pronto pulse; the outputs hold their reset values until a new operation completes.
REQ-028 The first iniciar SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-029 dividendo=13, divisor=3, iniciar pulse -> 4 cycles later pronto=1, quociente=4, resto=1, erro_div0=0.
REQ-030 15/1 -> quociente=15, resto=0; 5/7 -> quociente=0, resto=5; 15/15 -> 1, 0; each with a single-cycle pronto and ocupado high for 5 cycles.
REQ-031 9/0 -> next cycle pronto=1, erro_div0=1, quociente=4'hF, resto=9; a following 8/2 -> erro_div0=0, quociente=4, resto=0.
REQ-032 Start 12/5, re-pulse iniciar with 7/1 during CALC -> result 2, 2 only; no second pronto.
REQ-033 Start 14/3, assert rst after 2 CALC edges -> all outputs 0 immediately, no pronto; then 14/3 -> 4, 2.
REQ-034 iniciar held high with 10/3 -> pronto every 6 cycles, each result 3, 1.

Source files
------------

// File: rtl/divisor_sequencial_4bits.sv
// Restoring 4-bit unsigned divider: result 4 cycles after start (1 cycle on divide-by-zero).
// No backpressure: iniciar is ignored while busy; results hold until the next completion.
module divisor_sequencial_4bits (
    input  logic       clk,
    input  logic       rst,
    input  logic       iniciar,
    input  logic [3:0] dividendo,
    input  logic [3:0] divisor,
    output logic [3:0] quociente,
    output logic [3:0] resto,
    output logic       pronto,
    output logic       ocupado,
    output logic       erro_div0
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [1:0] cnt;
    logic [4:0] r;
    logic [3:0] q;
    logic [3:0] d;

    logic [5:0] trial;
    logic [4:0] r_step;
    logic [3:0] q_step;

    logic       accept;
    logic       div_zero;
    logic       last_step;
    logic       pronto_nxt;
    logic       ocupado_nxt;

    // One restoring step: shift {R,Q} left, subtract D, restore on borrow.
    always_comb begin
        trial  = {r, q[3]} - {2'b00, d};
        r_step = {r[3:0], q[3]};
        q_step = {q[2:0], 1'b0};
        if (!trial[5]) begin
            r_step = trial[4:0];
            q_step = {q[2:0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OCIOSO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            OCIOSO: begin
                if (iniciar) begin
                    next_state = (divisor == 4'd0) ? FIM : CALC;
                end
            end
            CALC: begin
                if (cnt == 2'd0) begin
                    next_state = FIM;
                end
            end
            FIM:     next_state = OCIOSO;
            default: next_state = OCIOSO;
        endcase
    end

    // Output logic: next-cycle values of the registered status outputs
    always_comb begin
        accept      = (state == OCIOSO) && iniciar;
        div_zero    = accept && (divisor == 4'd0);
        last_step   = (state == CALC) && (cnt == 2'd0);
        pronto_nxt  = (next_state == FIM);
        ocupado_nxt = (next_state != OCIOSO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            r         <= 5'd0;
            q         <= 4'd0;
            d         <= 4'd0;
            quociente <= 4'd0;
            resto     <= 4'd0;
            pronto    <= 1'b0;
            ocupado   <= 1'b0;
            erro_div0 <= 1'b0;
        end else begin
            pronto  <= pronto_nxt;
            ocupado <= ocupado_nxt;

            if (accept) begin
                d         <= divisor;
                q         <= dividendo;
                r         <= 5'd0;
                cnt       <= 2'd3;
                erro_div0 <= div_zero;
            end

            // Divide-by-zero completes straight from the sampling edge
            if (div_zero) begin
                quociente <= 4'hF;
                resto     <= dividendo;
            end

            if (state == CALC) begin
                r   <= r_step;
                q   <= q_step;
                cnt <= cnt - 2'd1;
            end

            if (last_step) begin
                quociente <= q_step;
                resto     <= r_step[3:0];
            end
        end
    end

endmodule
